bias_add_stream: RTL and testbench

- Consumer-side counterpart of the per-layer bias streamers.
- Reads one frame's bias coefficients from the bias FIFO into a local register file.
- Then reads the convolution accumulator stream, adds the per-channel bias with signed saturation, and writes the result to the output FIFO.
- Sits between a conv layer's accumulator output and the activation/requantisation stage; all stream ports use ap_fifo read/write semantics.

---
 rtl/bias_add_stream_if.sv | 35 +++
 rtl/bias_add_stream.sv | 131 +++++++++++++
 tb/tb_bias_add_stream.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bias_add_stream_if.sv
// Stream bundle for bias_add_stream: bias FIFO read side, accumulator FIFO
// read side and output FIFO write side, all with ap_fifo semantics.
// slave = the bias adder (pops bias/input, pushes output); master = the FIFO side.
interface bias_add_stream_if #(
   parameter int COEFF_WIDTH = 16,
   parameter int ACC_WIDTH   = 32
);
   logic [COEFF_WIDTH-1:0] bias_V_dout;
   logic                   bias_V_empty_n;
   logic                   bias_V_read;
   logic [ACC_WIDTH-1:0]   input_V_dout;
   logic                   input_V_empty_n;
   logic                   input_V_read;
   logic [ACC_WIDTH-1:0]   output_V_din;
   logic                   output_V_full_n;
   logic                   output_V_write;

   modport slave (
      input  bias_V_dout, bias_V_empty_n,
      output bias_V_read,
      input  input_V_dout, input_V_empty_n,
      output input_V_read,
      output output_V_din, output_V_write,
      input  output_V_full_n
   );

   modport master (
      output bias_V_dout, bias_V_empty_n,
      input  bias_V_read,
      output input_V_dout, input_V_empty_n,
      input  input_V_read,
      input  output_V_din, output_V_write,
      output output_V_full_n
   );
endinterface

// File: rtl/bias_add_stream.sv
// Loads one frame of per-channel biases, then adds them (saturating) to the
// channel-fastest accumulator stream. Latency: pop at edge t -> output from cycle t+1.
// Backpressure: a held output word stalls accumulator pops; empty inputs insert bubbles.
// Ports: ap_clk/ap_rst (sync, active-high), bus (slave view of the three FIFOs),
// frame_done (one-cycle pulse the cycle after a frame's last word is written).
module bias_add_stream #(
   parameter int COEFF_WIDTH  = 16,
   parameter int ACC_WIDTH    = 32,
   parameter int OUT_CHANNELS = 16,
   parameter int PIXELS       = 64
) (
   input  logic                ap_clk,
   input  logic                ap_rst,
   bias_add_stream_if.slave    bus,
   output logic                frame_done
);
   localparam int CW = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
   localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam logic [CW-1:0] CH_LAST  = CW'(OUT_CHANNELS - 1);
   localparam logic [PW-1:0] PIX_LAST = PW'(PIXELS - 1);
   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   typedef enum logic {LOAD, RUN} state_t;

   state_t                 state_q;
   logic [CW-1:0]          load_cnt_q;
   logic [CW-1:0]          ch_cnt_q;
   logic [PW-1:0]          pix_cnt_q;
   logic                   out_valid_q;
   logic                   out_last_q;
   logic                   frame_done_q;
   logic [ACC_WIDTH-1:0]   dout_q;
   logic [ACC_WIDTH-1:0]   dout_d;
   logic [COEFF_WIDTH-1:0] bias_q [OUT_CHANNELS];

   logic                   bias_rd;
   logic                   acc_rd;
   logic                   out_wr;
   logic                   adv;
   logic                   ch_wrap;
   logic                   frame_end;
   logic [COEFF_WIDTH-1:0] bias_sel;
   logic [ACC_WIDTH:0]     sum;

   assign bias_rd   = (state_q == LOAD) & bus.bias_V_empty_n;
   // The output register can take a new word if it is empty or being drained now.
   assign adv       = ~out_valid_q | bus.output_V_full_n;
   assign acc_rd    = (state_q == RUN) & bus.input_V_empty_n & adv;
   assign out_wr    = out_valid_q & bus.output_V_full_n;
   assign ch_wrap   = (ch_cnt_q == CH_LAST);
   assign frame_end = ch_wrap & (pix_cnt_q == PIX_LAST);

   assign bias_sel = bias_q[ch_cnt_q];
   // One extra bit of headroom so the overflow direction is visible in the top two bits.
   assign sum = {bus.input_V_dout[ACC_WIDTH-1], bus.input_V_dout}
              + {{(ACC_WIDTH+1-COEFF_WIDTH){bias_sel[COEFF_WIDTH-1]}}, bias_sel};

   always_comb begin
      dout_d = sum[ACC_WIDTH-1:0];
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
         dout_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end
   end

   // Bias storage survives reset; it is always fully rewritten before use.
   always_ff @(posedge ap_clk) begin
      if (bias_rd) begin
         bias_q[load_cnt_q] <= bus.bias_V_dout;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q      <= LOAD;
         load_cnt_q   <= '0;
         ch_cnt_q     <= '0;
         pix_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         dout_q       <= '0;
      end else begin
         frame_done_q <= out_wr & out_last_q;

         case (state_q)
            LOAD: begin
               if (bias_rd) begin
                  if (load_cnt_q == CH_LAST) begin
                     load_cnt_q <= '0;
                     state_q    <= RUN;
                  end else begin
                     load_cnt_q <= load_cnt_q + CW'(1);
                  end
               end
            end
            RUN: begin
               if (acc_rd) begin
                  if (frame_end) begin
                     ch_cnt_q  <= '0;
                     pix_cnt_q <= '0;
                     state_q   <= LOAD;
                  end else if (ch_wrap) begin
                     ch_cnt_q  <= '0;
                     pix_cnt_q <= pix_cnt_q + PW'(1);
                  end else begin
                     ch_cnt_q  <= ch_cnt_q + CW'(1);
                  end
               end
            end
            default: state_q <= LOAD;
         endcase

         // A pop refills the register (even while it drains); a bare write empties it.
         if (acc_rd) begin
            out_valid_q <= 1'b1;
            out_last_q  <= frame_end;
            dout_q      <= dout_d;
         end else if (out_wr) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
      end
   end

   assign bus.bias_V_read    = bias_rd;
   assign bus.input_V_read   = acc_rd;
   assign bus.output_V_write = out_wr;
   assign bus.output_V_din   = dout_q;
   assign frame_done         = frame_done_q;
endmodule

// File: tb/tb_bias_add_stream.sv
module tb_bias_add_stream;
   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
   logic frame_done;

   always #5 ap_clk = ~ap_clk;

   bias_add_stream_if #(.COEFF_WIDTH(16), .ACC_WIDTH(32)) bus ();

   bias_add_stream #(
      .COEFF_WIDTH(16), .ACC_WIDTH(32), .OUT_CHANNELS(4), .PIXELS(2)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .bus        (bus),
      .frame_done (frame_done)
   );

   logic [15:0] bq[$];
   logic [31:0] aq[$];
   logic [31:0] oq[$];
   int wr_cyc[$];
   int fd_cyc[$];
   int cyc = 0;
   int first_in_cyc;
   int bias_pops;
   int bias4_cyc;
   bit full_en = 1'b1;
   int n_vec = 0;
   int n_err = 0;
   logic [31:0] held;

   int exp_basic [8] = '{10, -4, 2, 10, 14, 0, 6, 14};
   int exp_sat   [8] = '{32'h7FFFFFFF, 32'h80000000, 5, -3, 32'h7FFFFFFF, 32'h80000000, 0, 0};
   int exp_plus1 [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
   int exp_rst   [8] = '{11, 13, 15, 17, 15, 17, 19, 21};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: present FIFO heads at the falling edge, then sample handshakes
   // and apply the pops/pushes that the next rising edge will perform.
   task automatic step();
      @(negedge ap_clk);
      bus.bias_V_empty_n  = (bq.size() > 0);
      bus.bias_V_dout     = (bq.size() > 0) ? bq[0] : 16'h0;
      bus.input_V_empty_n = (aq.size() > 0);
      bus.input_V_dout    = (aq.size() > 0) ? aq[0] : 32'h0;
      bus.output_V_full_n = full_en;
      #1;
      cyc++;
      if (bus.bias_V_read) begin
         void'(bq.pop_front());
         bias_pops++;
         if (bias_pops == 4) bias4_cyc = cyc;
      end
      if (bus.input_V_read) begin
         void'(aq.pop_front());
         if (first_in_cyc < 0) first_in_cyc = cyc;
      end
      if (bus.output_V_write) begin
         oq.push_back(bus.output_V_din);
         wr_cyc.push_back(cyc);
      end
      if (frame_done) fd_cyc.push_back(cyc);
   endtask

   task automatic clear_stats();
      oq.delete();
      wr_cyc.delete();
      fd_cyc.delete();
      first_in_cyc = -1;
      bias_pops    = 0;
      bias4_cyc    = -1;
   endtask

   task automatic push_frame(input int b0, input int b1, input int b2, input int b3, input int base);
      bq.push_back(16'(b0)); bq.push_back(16'(b1));
      bq.push_back(16'(b2)); bq.push_back(16'(b3));
      for (int k = 0; k < 8; k++) aq.push_back(32'(base + k));
   endtask

   task automatic run_until(input int n);
      for (int i = 0; i < 300 && oq.size() < n; i++) step();
      repeat (3) step();
      check("word_count", 32'(oq.size()), 32'(n));
   endtask

   initial begin
      bus.bias_V_dout = '0; bus.bias_V_empty_n = 1'b0;
      bus.input_V_dout = '0; bus.input_V_empty_n = 1'b0;
      bus.output_V_full_n = 1'b1;
      clear_stats();

      // Reset state
      ap_rst = 1'b1;
      step(); step();
      check("rst_write", 32'(bus.output_V_write), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_din", bus.output_V_din, 32'd0);
      check("rst_in_read", 32'(bus.input_V_read), 32'd0);
      ap_rst = 1'b0;

      // Basic frame
      clear_stats();
      push_frame(10, -5, 0, 7, 0);
      run_until(8);
      for (int i = 0; i < 8; i++) check($sformatf("basic_out%0d", i), oq[i], 32'(exp_basic[i]));
      check("basic_back_to_back", 32'(wr_cyc[7] - wr_cyc[0]), 32'd7);
      check("basic_fd_count", 32'(fd_cyc.size()), 32'd1);
      check("basic_fd_cycle", 32'(fd_cyc[0]), 32'(wr_cyc[7] + 1));

      // Accumulators waiting before biases
      clear_stats();
      for (int k = 0; k < 8; k++) aq.push_back(32'(k));
      repeat (3) step();
      check("order_no_early_pop", 32'(first_in_cyc), 32'hFFFFFFFF);
      bq.push_back(16'd10); repeat (3) step();
      bq.push_back(16'hFFFB); repeat (3) step();
      bq.push_back(16'd0); repeat (3) step();
      bq.push_back(16'd7); repeat (3) step();
      run_until(8);
      check("order_first_pop", 32'(first_in_cyc), 32'(bias4_cyc + 1));
      check("order_first_out", 32'(wr_cyc[0]), 32'(first_in_cyc + 1));
      for (int i = 0; i < 8; i++) check($sformatf("order_out%0d", i), oq[i], 32'(exp_basic[i]));

      // Output backpressure mid-frame
      clear_stats();
      push_frame(10, -5, 0, 7, 0);
      for (int i = 0; i < 100 && oq.size() < 3; i++) step();
      full_en = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step();
         check($sformatf("stall%0d_din", s), bus.output_V_din, 32'd10);
         check($sformatf("stall%0d_in_read", s), 32'(bus.input_V_read), 32'd0);
      end
      full_en = 1'b1;
      run_until(8);
      for (int i = 0; i < 8; i++) check($sformatf("bp_out%0d", i), oq[i], 32'(exp_basic[i]));
      check("bp_fd_count", 32'(fd_cyc.size()), 32'd1);

      // Saturation at both rails plus exact-boundary sums
      clear_stats();
      bq.push_back(16'd100); bq.push_back(16'hFF9C); bq.push_back(16'd0); bq.push_back(16'd0);
      aq.push_back(32'h7FFFFFF0); aq.push_back(32'h80000010);
      aq.push_back(32'd5);        aq.push_back(32'hFFFFFFFD);
      aq.push_back(32'h7FFFFF9B); aq.push_back(32'h80000064);
      aq.push_back(32'd0);        aq.push_back(32'd0);
      run_until(8);
      for (int i = 0; i < 8; i++) check($sformatf("sat_out%0d", i), oq[i], 32'(exp_sat[i]));

      // Two back-to-back frames
      clear_stats();
      push_frame(10, -5, 0, 7, 0);
      push_frame(1, 1, 1, 1, 0);
      run_until(16);
      for (int i = 0; i < 8; i++) check($sformatf("b2b_f0_out%0d", i), oq[i], 32'(exp_basic[i]));
      for (int i = 0; i < 8; i++) check($sformatf("b2b_f1_out%0d", i), oq[8+i], 32'(exp_plus1[i]));
      check("b2b_fd_count", 32'(fd_cyc.size()), 32'd2);

      // Reset mid-frame, then a fresh frame
      clear_stats();
      push_frame(10, -5, 0, 7, 0);
      for (int i = 0; i < 100 && oq.size() < 3; i++) step();
      bq.delete();
      aq.delete();
      ap_rst = 1'b1;
      step();
      ap_rst = 1'b0;
      clear_stats();
      push_frame(1, 2, 3, 4, 10);
      step();
      check("post_rst_write", 32'(bus.output_V_write), 32'd0);
      check("post_rst_bias_read", 32'(bus.bias_V_read), 32'(bus.bias_V_empty_n));
      check("post_rst_bias_read_hi", 32'(bus.bias_V_read), 32'd1);
      run_until(8);
      for (int i = 0; i < 8; i++) check($sformatf("rst_out%0d", i), oq[i], 32'(exp_rst[i]));
      check("rst_fd_count", 32'(fd_cyc.size()), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
